// File: rtl/alu_pkg.sv
// Shared opcode map, FSM encoding and flag layout for the sequential ALU.
// Both the ALU top and anything decoding its flags import this package.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_ADDC = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_INC  = 4'd4;
    localparam logic [3:0] OP_DEC  = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_ROL  = 4'd8;
    localparam logic [3:0] OP_ROR  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_ROLN = 4'd11;
    localparam logic [3:0] OP_RORN = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int NUM_FLAGS   = 5;
    localparam int FLG_CARRY   = 0;
    localparam int FLG_BORROW  = 1;
    localparam int FLG_ZERO    = 2;
    localparam int FLG_PARITY  = 3;
    localparam int FLG_INVALID = 4;

    typedef logic [NUM_FLAGS-1:0] flags_t;

    function automatic flags_t pack_flags(input logic carry, input logic borrow,
                                          input logic zero, input logic parity,
                                          input logic inv);
        flags_t f;
        f              = '0;
        f[FLG_CARRY]   = carry;
        f[FLG_BORROW]  = borrow;
        f[FLG_ZERO]    = zero;
        f[FLG_PARITY]  = parity;
        f[FLG_INVALID] = inv;
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle.
// done pulses for one cycle once product is final, BUS_WIDTH cycles after start.
module alu_mul_iter #(
    parameter int BUS_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [BUS_WIDTH-1:0]   a,
    input  logic [BUS_WIDTH-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [2*BUS_WIDTH-1:0] product
);

    localparam int CW = $clog2(BUS_WIDTH + 1);

    logic [BUS_WIDTH-1:0] acc;
    logic [BUS_WIDTH-1:0] mcand;
    logic [BUS_WIDTH-1:0] mplier;
    logic [CW-1:0]        cnt;
    logic [BUS_WIDTH:0]   psum;

    // The multiplier register doubles as the low half of the product.
    assign psum    = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
    assign product = {acc, mplier};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc    <= '0;
                mcand  <= a;
                mplier <= b;
                cnt    <= CW'(BUS_WIDTH);
                busy   <= 1'b1;
            end else if (busy) begin
                {acc, mplier} <= {psum, mplier[BUS_WIDTH-1:1]};
                cnt           <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_seq_nbit.sv
// Handshaked sequential ALU: single-cycle ops resolve in EXEC, MUL runs the
// iterative multiplier; results and flags are registered and held until taken.
module alu_seq_nbit #(
    parameter int BUS_WIDTH = 16,
    parameter int CARRY_SRC = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BUS_WIDTH-1:0] a,
    input  logic [BUS_WIDTH-1:0] b,
    input  logic                 carry_in,
    input  logic [3:0]           opcode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] y,
    output logic [BUS_WIDTH-1:0] y_hi,
    output logic                 carry_out,
    output logic                 borrow,
    output logic                 zero,
    output logic                 parity,
    output logic                 invalid_op
);
    import alu_pkg::*;

    localparam int W = BUS_WIDTH;
    localparam logic [W-1:0] W_AMT = W'(W);

    state_t             state, state_nxt;
    logic               accept, mul_start, mul_busy, mul_done, load_res;
    logic [W-1:0]       a_q, b_q;
    logic [3:0]         op_q;
    logic               cin_q, carry_flag, cin_sel;
    logic [2*W-1:0]     mul_prod;
    logic [W-1:0]       res, res_hi, amt;
    logic [W:0]         sum;
    logic               res_c, res_bw, res_inv;
    flags_t             flags_q;

    alu_mul_iter #(.BUS_WIDTH(W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid) state_nxt = (opcode == OP_MUL) ? ST_MUL : ST_EXEC;
            ST_EXEC: state_nxt = ST_DONE;
            ST_MUL:  if (mul_done && !mul_busy) state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
        accept    = in_ready & in_valid;
        mul_start = accept & (opcode == OP_MUL);
        load_res  = (state == ST_EXEC) | ((state == ST_MUL) & mul_done);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            cin_q <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= opcode;
            cin_q <= carry_in;
        end
    end

    assign cin_sel = (CARRY_SRC != 0) ? carry_flag : cin_q;
    // Rotate amount wraps modulo the width so non-power-of-two widths rotate correctly.
    assign amt     = b_q % W_AMT;

    always_comb begin
        res     = '0;
        res_hi  = '0;
        sum     = '0;
        res_c   = 1'b0;
        res_bw  = 1'b0;
        res_inv = 1'b0;
        case (op_q)
            OP_ADD: begin
                sum   = {1'b0, a_q} + {1'b0, b_q};
                res   = sum[W-1:0];
                res_c = sum[W];
            end
            OP_ADDC: begin
                sum   = {1'b0, a_q} + {1'b0, b_q} + {{W{1'b0}}, cin_sel};
                res   = sum[W-1:0];
                res_c = sum[W];
            end
            OP_SUB: begin
                res    = a_q - b_q;
                res_bw = (a_q < b_q);
            end
            OP_INC: begin
                sum   = {1'b0, a_q} + {{W{1'b0}}, 1'b1};
                res   = sum[W-1:0];
                res_c = sum[W];
            end
            OP_DEC: begin
                res    = a_q - {{(W-1){1'b0}}, 1'b1};
                res_bw = (a_q == '0);
            end
            OP_AND:  res = a_q & b_q;
            OP_NOT:  res = ~a_q;
            OP_ROL:  res = {a_q[W-2:0], a_q[W-1]};
            OP_ROR:  res = {a_q[0], a_q[W-1:1]};
            OP_MUL: begin
                res    = mul_prod[W-1:0];
                res_hi = mul_prod[2*W-1:W];
                res_c  = |mul_prod[2*W-1:W];
            end
            // A shift by the full width yields zero, so amt==0 returns a unchanged.
            OP_ROLN: res = (a_q << amt) | (a_q >> (W_AMT - amt));
            OP_RORN: res = (a_q >> amt) | (a_q << (W_AMT - amt));
            default: res_inv = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y       <= '0;
            y_hi    <= '0;
            flags_q <= '0;
        end else if (load_res) begin
            y       <= res;
            y_hi    <= res_hi;
            flags_q <= pack_flags(res_c, res_bw, ({res_hi, res} == '0), ^res, res_inv);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            carry_flag <= 1'b0;
        else if ((state == ST_EXEC) &&
                 ((op_q == OP_ADD) || (op_q == OP_ADDC) || (op_q == OP_INC)))
            carry_flag <= res_c;
    end

    assign carry_out  = flags_q[FLG_CARRY];
    assign borrow     = flags_q[FLG_BORROW];
    assign zero       = flags_q[FLG_ZERO];
    assign parity     = flags_q[FLG_PARITY];
    assign invalid_op = flags_q[FLG_INVALID];

endmodule

// File: tb/tb_alu_seq_nbit.sv
// Scoreboard bench for alu_seq_nbit: two instances (port carry / internal carry)
// driven in lockstep, expected results queued at drive time and popped at output.
module tb_alu_seq_nbit;

    localparam int W = 16;

    logic          clk = 1'b0, rst = 1'b1, in_valid = 1'b0, carry_in = 1'b0, out_ready = 1'b0;
    logic [W-1:0]  a = '0, b = '0;
    logic [3:0]    opcode = '0;
    logic          in_ready0, in_ready1, out_valid0, out_valid1;
    logic [W-1:0]  y0, yh0, y1, yh1;
    logic          co0, bw0, z0, p0, inv0, co1, bw1, z1, p1, inv1;
    logic [4:0]    fl0, fl1;
    logic          cflag = 1'b0;
    int            n_cmp = 0, n_err = 0;

    typedef struct {
        logic [15:0] y, yh, y1, yh1;
        logic [4:0]  fl, fl1;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    assign fl0 = {inv0, p0, z0, bw0, co0};
    assign fl1 = {inv1, p1, z1, bw1, co1};

    alu_seq_nbit #(.BUS_WIDTH(W), .CARRY_SRC(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .carry_in(carry_in), .opcode(opcode),
        .out_valid(out_valid0), .out_ready(out_ready), .y(y0), .y_hi(yh0),
        .carry_out(co0), .borrow(bw0), .zero(z0), .parity(p0), .invalid_op(inv0)
    );

    alu_seq_nbit #(.BUS_WIDTH(W), .CARRY_SRC(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .carry_in(carry_in), .opcode(opcode),
        .out_valid(out_valid1), .out_ready(out_ready), .y(y1), .y_hi(yh1),
        .carry_out(co1), .borrow(bw1), .zero(z1), .parity(p1), .invalid_op(inv1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour written from the opcode table; flags as {inv,par,zero,borrow,carry}.
    function automatic void model(input logic [3:0] op, input logic [15:0] ma, input logic [15:0] mb,
                                  input logic ci, output logic [15:0] ry, output logic [15:0] ryh,
                                  output logic [4:0] rfl);
        logic [16:0] s;
        logic [31:0] p;
        logic        c, bw, inv;
        int          n;
        ry = '0; ryh = '0; c = 1'b0; bw = 1'b0; inv = 1'b0;
        case (op)
            4'd1:  begin s = {1'b0, ma} + {1'b0, mb}; ry = s[15:0]; c = s[16]; end
            4'd2:  begin s = {1'b0, ma} + {1'b0, mb} + {16'd0, ci}; ry = s[15:0]; c = s[16]; end
            4'd3:  begin ry = ma - mb; bw = (ma < mb); end
            4'd4:  begin ry = ma + 16'd1; c = (ma == 16'hFFFF); end
            4'd5:  begin ry = ma - 16'd1; bw = (ma == 16'd0); end
            4'd6:  ry = ma & mb;
            4'd7:  ry = ~ma;
            4'd8:  ry = {ma[14:0], ma[15]};
            4'd9:  ry = {ma[0], ma[15:1]};
            4'd10: begin p = 32'(ma) * 32'(mb); ry = p[15:0]; ryh = p[31:16]; c = (ryh != 0); end
            4'd11: begin ry = ma; n = int'(mb) % 16; repeat (n) ry = {ry[14:0], ry[15]}; end
            4'd12: begin ry = ma; n = int'(mb) % 16; repeat (n) ry = {ry[0], ry[15:1]}; end
            default: inv = 1'b1;
        endcase
        rfl = {inv, ^ry, ({ryh, ry} == 32'd0), bw, c};
    endfunction

    task automatic send(input logic [3:0] op, input logic [15:0] sa, input logic [15:0] sbv,
                        input logic ci, input int hold);
        exp_t e;
        int   t, lat;
        t = 0;
        @(negedge clk);
        while (!in_ready0 && t < 50) begin @(negedge clk); t++; end
        chk("in_ready_wait", 64'(in_ready0), 64'd1);
        in_valid = 1'b1; opcode = op; a = sa; b = sbv; carry_in = ci;
        model(op, sa, sbv, ci, e.y, e.yh, e.fl);
        model(op, sa, sbv, cflag, e.y1, e.yh1, e.fl1);
        if (op == 4'd1 || op == 4'd2 || op == 4'd4) cflag = e.fl1[0];
        sb.push_back(e);
        @(posedge clk); #1;
        // Scramble inputs after acceptance: results must come from captured values.
        in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom);
        opcode = 4'($urandom); carry_in = 1'($urandom);
        lat = 0;
        while (!out_valid0 && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("latency", 64'(lat), (op == 4'd10) ? 64'd17 : 64'd1);
        e = sb.pop_front();
        if (!out_valid0) return;
        for (int k = 0; k <= hold; k++) begin
            chk("y",         64'(y0),  64'(e.y));
            chk("y_hi",      64'(yh0), 64'(e.yh));
            chk("flags",     64'(fl0), 64'(e.fl));
            chk("y_cs1",     64'(y1),  64'(e.y1));
            chk("y_hi_cs1",  64'(yh1), 64'(e.yh1));
            chk("flags_cs1", 64'(fl1), 64'(e.fl1));
            chk("out_valid_cs1", 64'(out_valid1), 64'd1);
            chk("in_ready_busy", 64'(in_ready0), 64'd0);
            if (k < hold) begin @(posedge clk); #1; end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_drop", 64'(out_valid0), 64'd0);
        chk("in_ready_back",  64'(in_ready0),  64'd1);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid0), 64'd0);
        chk("rst_y",         64'({yh0, y0}),  64'd0);
        chk("rst_flags",     64'({fl1, fl0}), 64'd0);
        chk("rst_in_ready",  64'(in_ready0),  64'd1);
        rst = 1'b0;

        send(4'd1,  16'hFFFF, 16'h0001, 1'b0, 0);   // carry out, zero result
        send(4'd2,  16'h0000, 16'h0000, 1'b0, 0);   // cs1 instance adds stored carry
        send(4'd10, 16'h1234, 16'h0100, 1'b0, 0);
        send(4'd12, 16'h0001, 16'h0011, 1'b0, 0);
        send(4'd12, 16'hA5C3, 16'h0000, 1'b0, 0);
        send(4'd11, 16'h8001, 16'h0013, 1'b0, 0);
        send(4'd3,  16'h0003, 16'h0005, 1'b0, 0);
        send(4'd3,  16'h7777, 16'h7777, 1'b0, 0);
        send(4'd4,  16'hFFFF, 16'h0000, 1'b0, 0);
        send(4'd5,  16'h0000, 16'h0000, 1'b0, 0);
        send(4'd2,  16'h1000, 16'h0001, 1'b1, 0);
        send(4'd6,  16'hF0F0, 16'h3C3C, 1'b0, 0);
        send(4'd8,  16'h8001, 16'h0000, 1'b0, 0);
        send(4'd9,  16'h8001, 16'h0000, 1'b0, 0);
        send(4'd10, 16'hFFFF, 16'hFFFF, 1'b0, 0);
        send(4'd10, 16'h0000, 16'hBEEF, 1'b0, 0);
        send(4'hF,  16'h1234, 16'h5678, 1'b1, 5);   // invalid op, held output
        send(4'h0,  16'hFFFF, 16'hFFFF, 1'b1, 2);
        for (int i = 0; i < 12; i++)
            send(4'($urandom_range(15, 0)), 16'($urandom), 16'($urandom), 1'($urandom), i % 3);

        // Arm the internal carry and leave a nonzero result in the output registers.
        send(4'd1, 16'hFFFF, 16'h0002, 1'b0, 0);
        send(4'd7, 16'h0000, 16'h0000, 1'b0, 0);

        // Reset mid-multiply while a new request and an ack are also presented.
        @(negedge clk);
        in_valid = 1'b1; opcode = 4'd10; a = 16'h1234; b = 16'h5678;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; opcode = 4'd1; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cflag = 1'b0;
        chk("midmul_out_valid", 64'(out_valid0), 64'd0);
        chk("midmul_in_ready",  64'(in_ready0),  64'd1);
        chk("midmul_y",         64'({yh0, y0}),  64'd0);
        chk("midmul_flags",     64'(fl0),        64'd0);
        send(4'd1, 16'h0005, 16'h0007, 1'b0, 0);
        send(4'd2, 16'h0001, 16'h0001, 1'b0, 0);   // stored carry must be clear again

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
